// File: rtl/ldtu_hamm_ofifo_reader.sv
// Read side of the Hamming-protected output FIFO: fetches 38-bit codewords,
// corrects single-bit errors and hands 32-bit words to the serializer.
// Ports: CLK, reset_ (async, active-low), enable, fifo_empty/fifo_rd/
//   fifo_valid/fifo_data (FIFO read port), dout/dout_valid/dout_ready/
//   dout_corrected/dout_uncorr (output stream), err_corr_cnt/err_uncorr_cnt,
//   cnt_clear (counter control).
// Build option: LDTU_HAMM_RDR_CNT_EN enables the saturating error counters;
//   without it the counters read 0 and cnt_clear is ignored.
module ldtu_hamm_ofifo_reader #(
  parameter int NBITS_HAM  = 38,
  parameter int NBITS_DATA = 32,
  parameter int NPAR       = 6,
  parameter int OBUF_DEPTH = 2,
  parameter int CNT_W      = 8
) (
  input  logic                  CLK,
  input  logic                  reset_,
  input  logic                  enable,
  input  logic                  fifo_empty,
  output logic                  fifo_rd,
  input  logic                  fifo_valid,
  input  logic [NBITS_HAM-1:0]  fifo_data,
  output logic [NBITS_DATA-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_corrected,
  output logic                  dout_uncorr,
  output logic [CNT_W-1:0]      err_corr_cnt,
  output logic [CNT_W-1:0]      err_uncorr_cnt,
  input  logic                  cnt_clear
);

  localparam int PW = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
  localparam int CW = $clog2(OBUF_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(OBUF_DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(OBUF_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  state_e state_q;

  logic [CW-1:0] pend_q, pend_d;
  logic          rd_q;

  logic                 s1_v_q;
  logic [NBITS_HAM-1:0] cw_q;
  logic [NPAR-1:0]      syn_q, syn_d;

  logic [NBITS_HAM-1:0]  fixed;
  logic [NBITS_DATA-1:0] dec_data;
  logic                  dec_corr;
  logic                  dec_unc;

  logic [NBITS_DATA-1:0] data_q [OBUF_DEPTH];
  logic                  corr_q [OBUF_DEPTH];
  logic                  unc_q  [OBUF_DEPTH];
  logic [PW-1:0]         wp_q, rp_q;
  logic [CW-1:0]         cnt_q;

  logic accept;
  logic refused;
  logic push;
  logic pop;

  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
    return (p == LAST_C) ? '0 : p + PW'(1);
  endfunction

  // pend_q counts reads issued but not yet popped, which bounds
  // the buffer occupancy and keeps it from overflowing.
  assign fifo_rd = (state_q == RUN) & ~fifo_empty
                 & (pend_q < DEPTH_C);

  // Only the strobe answering our own read is taken.
  assign accept  = fifo_valid & rd_q;
  assign refused = rd_q & ~fifo_valid;
  assign push    = s1_v_q;
  assign pop     = dout_valid & dout_ready;

  assign pend_d = pend_q + CW'(fifo_rd)
                - CW'(pop) - CW'(refused);

  always_comb begin
    syn_d = '0;
    for (int j = 0; j < NPAR; j++) begin
      for (int i = 0; i < NBITS_HAM; i++) begin
        if ((((i + 1) >> j) & 1) != 0) begin
          syn_d[j] = syn_d[j] ^ fifo_data[i];
        end
      end
    end
  end

  always_comb begin : dec
    int k;
    fixed    = cw_q;
    dec_corr = 1'b0;
    dec_unc  = 1'b0;
    dec_data = '0;
    k        = 0;
    if (syn_q != '0) begin
      if (int'(syn_q) <= NBITS_HAM) dec_corr = 1'b1;
      else                          dec_unc  = 1'b1;
    end
    for (int i = 0; i < NBITS_HAM; i++) begin
      if (dec_corr && (int'(syn_q) == i + 1)) begin
        fixed[i] = ~fixed[i];
      end
    end
    // Data bits live at the non-power-of-2 positions.
    for (int p = 1; p <= NBITS_HAM; p++) begin
      if ((p & (p - 1)) != 0) begin
        dec_data[k] = fixed[p-1];
        k = k + 1;
      end
    end
  end

  always_ff @(posedge CLK or negedge reset_) begin
    if (!reset_) begin
      state_q <= IDLE;
      pend_q  <= '0;
      rd_q    <= 1'b0;
      s1_v_q  <= 1'b0;
      cw_q    <= '0;
      syn_q   <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < OBUF_DEPTH; i++) begin
        data_q[i] <= '0;
        corr_q[i] <= 1'b0;
        unc_q[i]  <= 1'b0;
      end
    end else begin
      case (state_q)
        IDLE:    if (enable) state_q <= RUN;
        RUN:     if (!enable) state_q <= DRAIN;
        DRAIN: begin
          if (enable)              state_q <= RUN;
          else if (pend_q == '0)   state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      pend_q <= pend_d;
      rd_q   <= fifo_rd;
      s1_v_q <= accept;
      if (accept) begin
        cw_q  <= fifo_data;
        syn_q <= syn_d;
      end
      if (push) begin
        data_q[wp_q] <= dec_data;
        corr_q[wp_q] <= dec_corr;
        unc_q[wp_q]  <= dec_unc;
        wp_q         <= inc_ptr(wp_q);
      end
      if (pop) rp_q <= inc_ptr(rp_q);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  assign dout_valid     = (cnt_q != '0);
  assign dout           = data_q[rp_q];
  assign dout_corrected = corr_q[rp_q];
  assign dout_uncorr    = unc_q[rp_q];

`ifdef LDTU_HAMM_RDR_CNT_EN
  logic [CNT_W-1:0] ccnt_q, ucnt_q;

  always_ff @(posedge CLK or negedge reset_) begin
    if (!reset_) begin
      ccnt_q <= '0;
      ucnt_q <= '0;
    end else if (cnt_clear) begin
      ccnt_q <= '0;
      ucnt_q <= '0;
    end else begin
      if (push && dec_corr && (ccnt_q != '1)) begin
        ccnt_q <= ccnt_q + CNT_W'(1);
      end
      if (push && dec_unc && (ucnt_q != '1)) begin
        ucnt_q <= ucnt_q + CNT_W'(1);
      end
    end
  end

  assign err_corr_cnt   = ccnt_q;
  assign err_uncorr_cnt = ucnt_q;
`else
  logic unused_cnt_clear;
  assign unused_cnt_clear = cnt_clear;
  assign err_corr_cnt     = '0;
  assign err_uncorr_cnt   = '0;
`endif

endmodule
